control_unit: RTL

- Moore FSM that sequences the bus datapath: fetch, decode and execute.
- Replaces the hand-written state sequencing used in datapath benches.
- Drives every datapath control strobe from a state register and the opcode in IRVal[31:27]. Uses the CON flag for conditional branches.
- Sits beside datapath in the top level. Outputs wire 1:1 to datapath control inputs.

---
 rtl/control_unit_pkg.sv | 118 +++++++++++
 rtl/control_unit_if.sv | 35 +++
 rtl/control_unit_alu_op_decode.sv | 14 +
 rtl/control_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// ----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the control unit:
//   - 5-bit opcode encodings taken from IRVal[31:27]
//   - FSM state encoding (4-bit) and instruction class enum
//   - ALU-select and full control-word packed structs
//   - helper functions: opcode -> class, opcode -> ALU one-hot,
//     class -> last execute state
// ----------------------------------------------------------------------------
package control_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10100;
    localparam logic [4:0] OP_OUT  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        RESET_ST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_MULDIV, C_UNARY,
        C_BR, C_JR, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } op_class_t;

    typedef struct packed {
        logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    } alu_sel_t;

    // Field order matches the concatenation that drives the interface.
    typedef struct packed {
        logic     run, illegal;
        logic     PCin, IRin, MARin, MDRin, RYin, RZin, HILOin, CONin, OUTPUTin, Rin;
        logic     PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout;
        logic     Gra, Grb, Grc;
        logic     Read, Write;
        alu_sel_t alu;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_LD:                         cls = C_LD;
            OP_LDI:                        cls = C_LDI;
            OP_ST:                         cls = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: cls = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:      cls = C_IMM;
            OP_MUL, OP_DIV:                cls = C_MULDIV;
            OP_NEG, OP_NOT:                cls = C_UNARY;
            OP_BR:                         cls = C_BR;
            OP_JR:                         cls = C_JR;
            OP_IN:                         cls = C_IN;
            OP_OUT:                        cls = C_OUT;
            OP_NOP:                        cls = C_NOP;
            OP_HALT:                       cls = C_HALT;
            default:                       cls = C_ILL;
        endcase
        return cls;
    endfunction

    // ALU operation owned by the opcode itself; address/branch adds are
    // issued directly by the FSM and are not part of this map.
    function automatic alu_sel_t alu_sel(input logic [4:0] op);
        alu_sel_t s;
        s = '0;
        case (op)
            OP_ADD, OP_ADDI: s.ADD    = 1'b1;
            OP_SUB:          s.SUB    = 1'b1;
            OP_AND, OP_ANDI: s.AND    = 1'b1;
            OP_OR,  OP_ORI:  s.OR     = 1'b1;
            OP_ROR:          s.ROR    = 1'b1;
            OP_ROL:          s.ROL    = 1'b1;
            OP_SHR:          s.SHR    = 1'b1;
            OP_SHL:          s.SHL    = 1'b1;
            OP_MUL:          s.MUL    = 1'b1;
            OP_DIV:          s.DIV    = 1'b1;
            OP_NEG:          s.NEGATE = 1'b1;
            OP_NOT:          s.NOT    = 1'b1;
            default:         s        = '0;
        endcase
        return s;
    endfunction

    function automatic state_t last_state(input op_class_t cls);
        state_t st;
        case (cls)
            C_LD, C_ST:                    st = T7;
            C_BR:                          st = T6;
            C_LDI, C_RTYPE, C_IMM, C_MULDIV: st = T5;
            C_UNARY:                       st = T4;
            default:                       st = T3;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// ----------------------------------------------------------------------------
// control_unit_if
// Bundles the control unit's datapath-facing signals.
//   inputs to the FSM : IRVal, CON, stop
//   outputs           : run, illegal, register load enables, bus drivers,
//                       register-field selects, memory strobes, ALU selects
// Modports: master = datapath/bench side, slave = control_unit side.
// ----------------------------------------------------------------------------
interface control_unit_if #(parameter int BITS = 32);
    logic [BITS-1:0] IRVal;
    logic CON, stop;
    logic run, illegal;
    logic PCin, IRin, MARin, MDRin, RYin, RZin, HILOin, CONin, OUTPUTin, Rin;
    logic PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout;
    logic Gra, Grb, Grc, Read, Write;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;

    modport master (
        output IRVal, CON, stop,
        input  run, illegal,
        input  PCin, IRin, MARin, MDRin, RYin, RZin, HILOin, CONin, OUTPUTin, Rin,
        input  PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout,
        input  Gra, Grb, Grc, Read, Write,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC
    );

    modport slave (
        input  IRVal, CON, stop,
        output run, illegal,
        output PCin, IRin, MARin, MDRin, RYin, RZin, HILOin, CONin, OUTPUTin, Rin,
        output PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout,
        output Gra, Grb, Grc, Read, Write,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC
    );
endinterface

// File: rtl/control_unit_alu_op_decode.sv
// ----------------------------------------------------------------------------
// alu_op_decode
// Maps the registered opcode onto the 13 ALU select lines (one-hot or zero).
//   i_op  : 5-bit opcode
//   o_sel : ALU select struct (IncPC never set here)
// ----------------------------------------------------------------------------
module alu_op_decode
    import control_pkg::*;
(
    input  logic [4:0] i_op,
    output alu_sel_t   o_sel
);
    assign o_sel = alu_sel(i_op);
endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Moore FSM sequencing fetch / decode / execute for the bus datapath.
//   clk   : system clock, all state changes on posedge
//   reset : synchronous, active-low
//   bus   : control_unit_if slave (IRVal, CON, stop in; all strobes out)
// Strobes are decoded from the state and the opcode captured on T2->T3;
// the only exception is PCin in branch T6, which follows CON.
// ----------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
#(
    parameter int BITS   = 32,
    parameter int OP_MSB = 31
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.slave  bus
);
    state_t          r_state, w_next;
    logic [4:0]      r_op;
    logic            r_stop_req;
    logic [BITS-1:0] w_ir;
    op_class_t       w_cls;
    alu_sel_t        w_alu;
    ctrl_t           w_ctrl;

    assign w_ir  = bus.IRVal;
    assign w_cls = op_class(r_op);

    alu_op_decode u_alu_dec (.i_op(r_op), .o_sel(w_alu));

    // State, opcode capture and sticky stop request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= RESET_ST;
            r_op       <= 5'd0;
            r_stop_req <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_stop_req <= r_stop_req | bus.stop;
            if (r_state == T2) begin
                r_op <= w_ir[OP_MSB -: 5];
            end
        end
    end

    // Next-state: linear fetch, execute runs to the class's last state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET_ST: w_next = T0;
            T0:       w_next = T1;
            T1:       w_next = T2;
            T2:       w_next = T3;
            T3, T4, T5, T6, T7: begin
                if (r_state == T3 && w_cls == C_HALT) begin
                    w_next = HALT;
                end else if (r_state == last_state(w_cls)) begin
                    w_next = r_stop_req ? HALT : T0;
                end else begin
                    w_next = state_t'(r_state + 4'd1);
                end
            end
            HALT:     w_next = HALT;
            default:  w_next = RESET_ST;
        endcase
    end

    // Control-word decode for the current state.
    always_comb begin
        w_ctrl     = '0;
        w_ctrl.run = (r_state >= T0) && (r_state <= T7);
        case (r_state)
            T0: begin
                w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1;
                w_ctrl.alu.IncPC = 1'b1; w_ctrl.RZin = 1'b1;
            end
            T1: begin
                w_ctrl.RZout = 1'b1; w_ctrl.PCin = 1'b1;
                w_ctrl.Read = 1'b1; w_ctrl.MDRin = 1'b1;
            end
            T2: begin
                w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
            end
            T3: begin
                case (w_cls)
                    C_LD, C_LDI, C_ST: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    C_RTYPE, C_IMM: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    C_MULDIV: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    C_UNARY: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.alu = w_alu; w_ctrl.RZin = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.CONin = 1'b1;
                    end
                    C_JR: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1;
                    end
                    C_IN: begin
                        w_ctrl.INPUTout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    C_OUT: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.OUTPUTin = 1'b1;
                    end
                    C_ILL:   w_ctrl.illegal = 1'b1;
                    default: w_ctrl.illegal = 1'b0;
                endcase
            end
            T4: begin
                case (w_cls)
                    C_LD, C_LDI, C_ST: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.alu.ADD = 1'b1; w_ctrl.RZin = 1'b1;
                    end
                    C_RTYPE: begin
                        w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.alu = w_alu; w_ctrl.RZin = 1'b1;
                    end
                    C_IMM: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.alu = w_alu; w_ctrl.RZin = 1'b1;
                    end
                    C_MULDIV: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1;
                        w_ctrl.alu = w_alu; w_ctrl.RZin = 1'b1;
                    end
                    C_UNARY: begin
                        w_ctrl.RZout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl.PCout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    default: w_ctrl.RZin = 1'b0;
                endcase
            end
            T5: begin
                case (w_cls)
                    C_LD, C_ST: begin
                        w_ctrl.RZout = 1'b1; w_ctrl.MARin = 1'b1;
                    end
                    C_LDI, C_RTYPE, C_IMM: begin
                        w_ctrl.RZout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    C_MULDIV: begin
                        w_ctrl.RZout = 1'b1; w_ctrl.HILOin = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.alu.ADD = 1'b1; w_ctrl.RZin = 1'b1;
                    end
                    default: w_ctrl.RZout = 1'b0;
                endcase
            end
            T6: begin
                case (w_cls)
                    C_LD: begin
                        w_ctrl.Read = 1'b1; w_ctrl.MDRin = 1'b1;
                    end
                    C_ST: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1;
                    end
                    C_BR: begin
                        // Branch taken only when the condition flag is set.
                        w_ctrl.RZout = 1'b1; w_ctrl.PCin = bus.CON;
                    end
                    default: w_ctrl.Read = 1'b0;
                endcase
            end
            T7: begin
                case (w_cls)
                    C_LD: begin
                        w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    C_ST:    w_ctrl.Write = 1'b1;
                    default: w_ctrl.Write = 1'b0;
                endcase
            end
            default: w_ctrl.run = 1'b0;
        endcase
    end

    assign {bus.run, bus.illegal,
            bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.RYin, bus.RZin,
            bus.HILOin, bus.CONin, bus.OUTPUTin, bus.Rin,
            bus.PCout, bus.MDRout, bus.RZout, bus.HILOout, bus.INPUTout,
            bus.Cout, bus.BAout, bus.Rout,
            bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.Write,
            bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHL, bus.ROR,
            bus.ROL, bus.AND, bus.OR, bus.NEGATE, bus.NOT, bus.IncPC} = w_ctrl;

endmodule
